mips_mem_bridge: RTL and testbench
==================================

// Module: mips_mem_bridge
// PURPOSE
//  Sits between the 5-stage MIPS core and a single SRAM-like bus (req/addr_ok/data_ok).
//  Replaces the core's zero-latency instruction and data ports with handshaked transfers.
//  Arbitrates the fetch (F) and memory (M) channels onto the one bus.
//  Raises stall requests to the hazard logic until each transfer completes.
// PARAMETERS
//  ADDR_W    32  bus and core address width
//  DATA_W    32  bus and core data width; must be 32 or 64
//  D_FIRST   1   1: M channel wins a simultaneous request; 0: F channel wins
// PORTS
//  clk          in   1       core clock; all logic on posedge
//  rst          in   1       asynchronous, active-low reset
//  inst_en      in   1       F stage wants an instruction at pcF
//  pcF          in   ADDR_W  fetch address
//  instrF       out  DATA_W  fetched instruction; valid when stall_if=0
//  mem_en       in   1       M stage load/store present
//  mem_wr       in   1       1=store, 0=load
//  mem_size     in   2       0=byte, 1=half, 2=word
//  aluoutM      in   ADDR_W  data address
//  writedataM   in   DATA_W  store data, already lane-aligned by the core
//  readdataM    out  DATA_W  load data; valid when stall_mem=0
//  advance      in   1       pipeline moves this cycle (no stall from any source)
//  flushF       in   1       redirect: discard the current fetch result
//  stall_if     out  1       fetch not yet complete
//  stall_mem    out  1       load/store not yet complete
//  bus_req      out  1       bus request
//  bus_wr       out  1       bus write
//  bus_size     out  2       bus transfer size
//  bus_addr     out  ADDR_W  bus address
//  bus_wdata    out  DATA_W  bus write data
//  bus_addr_ok  in   1       request accepted
//  bus_data_ok  in   1       response / write done
//  bus_rdata    in   DATA_W  read data
// BEHAVIOUR
//  Reset: state=IDLE; bus_req=0, bus_wr=0, bus_size=0, bus_addr=0, bus_wdata=0;
//   i_done=d_done=0, i_buf=d_buf=0, discard=0; stall_* follow their equations from these.
//  FSM: IDLE -> I_ADDR / D_ADDR; X_ADDR -> X_WAIT on bus_addr_ok; X_WAIT -> IDLE on bus_data_ok.
//   Leave IDLE only when the channel is enabled and its done flag is clear.
//   Both channels eligible: D_FIRST selects the winner.
//   One transaction in flight at most.
//  Bus outputs: bus_req=1 only in X_ADDR.
//   Address, size, wr and wdata are captured on IDLE exit and held stable until bus_addr_ok.
//   Fetch always issues size=2, wr=0.
//  Completion: bus_data_ok in I_WAIT sets i_done and loads i_buf=bus_rdata,
//   unless discard=1: then the result is dropped and the fetch reissues.
//   bus_data_ok in D_WAIT sets d_done; loads also load d_buf.
//  Forwarding: instrF = (I_WAIT & bus_data_ok) ? bus_rdata : i_buf. readdataM likewise.
//   Zero extra cycle on the completion edge.
//  stall_if  = inst_en & ~i_done & ~(I_WAIT & bus_data_ok & ~discard)
//  stall_mem = mem_en  & ~d_done & ~(D_WAIT & bus_data_ok)
//  Retire: advance=1 clears i_done and d_done at the clock edge.
//   Held results survive any number of advance=0 cycles.
//  flushF: clears i_done.
//   If the F transaction is in I_ADDR past the handshake, or in I_WAIT: set discard.
//   Discard clears on that transaction's bus_data_ok.
//   A request still in I_ADDR without bus_addr_ok stays on the bus; the bus protocol forbids withdrawal.
//  Simultaneous flushF and bus_data_ok in I_WAIT: the data is discarded; i_done stays 0.
//  Simultaneous advance and completion: the completion wins for the next op only if issued after the edge.
//   Implementation: clear happens first, set second.
//  Latency: minimum 2 cycles request->data (addr_ok in the issue cycle, data_ok the next).
//   No upper bound; stalls hold indefinitely.
//  DATA_W=64: bus_size is passed unchanged. Lane selection is the core's responsibility.
//  Mid-operation reset: FSM, flags and bus outputs go to reset values immediately.
//   The slave shares rst, so no stale data_ok is expected.
// STRUCTURE
//  Shared package (defines.h): bus size codes SZ_BYTE/SZ_HALF/SZ_WORD; FSM state encodings.
//  One sub-module, mips_mem_chan: done flag, result buffer, forwarding mux and stall equation.
//   Instanced twice (F with discard enabled, M without).
//  Top level holds the arbiter FSM and the bus output registers.
// TESTING
//  1 Fetch pcF=0xBFC00000, addr_ok same cycle, data_ok +1 with rdata=0x24080001
//    -> instrF=0x24080001 on the data_ok cycle; stall_if high exactly 2 cycles.
//  2 F and M both request (load 0x80001000, size=2) with D_FIRST=1
//    -> bus shows the M address first; F issues only after the M data_ok; stall_if held throughout.
//  3 Store byte 0x80000003, wdata=0xAB000000, addr_ok delayed 3 cycles
//    -> bus_req, addr, size=0, wdata stable all 4 cycles; stall_mem drops on data_ok.
//  4 Fetch completes with advance=0 for 5 cycles
//    -> instrF stays at the buffered value; no second bus request; the advance pulse clears i_done.
//  5 flushF asserted in I_WAIT, data_ok next cycle with rdata=0xDEADBEEF
//    -> 0xDEADBEEF never seen on instrF; a new fetch issues at the updated pcF.
//  6 rst low while in D_WAIT
//    -> bus_req=0, stall flags equal mem_en/inst_en, FSM=IDLE in the same cycle.

Source files
------------

// File: rtl/mips_mem_bridge_pkg.sv
// Shared definitions for the MIPS memory bridge:
// bus size codes and arbiter state encodings.
package mips_mem_bridge_pkg;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    I_ADDR = 3'd1,
    I_WAIT = 3'd2,
    D_ADDR = 3'd3,
    D_WAIT = 3'd4
  } state_e;

  typedef struct packed {
    logic       wr;
    logic [1:0] size;
  } bus_ctl_t;

endpackage

// File: rtl/mips_mem_bridge_if.sv
// SRAM-like bus with req/addr_ok/data_ok handshake.
// master = bridge side, slave = memory side.
interface mips_mem_bridge_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              req;
  logic              wr;
  logic [1:0]        size;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              addr_ok;
  logic              data_ok;
  logic [DATA_W-1:0] rdata;

  modport master (
    output req, wr, size, addr, wdata,
    input  addr_ok, data_ok, rdata
  );

  modport slave (
    input  req, wr, size, addr, wdata,
    output addr_ok, data_ok, rdata
  );
endinterface

// File: rtl/mips_mem_chan.sv
// One core-side channel: done flag, result buffer,
// same-cycle forwarding and stall equation.
module mips_mem_chan #(
  parameter int DATA_W      = 32,
  parameter bit HAS_DISCARD = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              advance,
  input  logic              flush,
  input  logic              issued,
  input  logic              in_wait,
  input  logic              data_ok,
  input  logic              load,
  input  logic [DATA_W-1:0] rdata,
  output logic [DATA_W-1:0] result,
  output logic              done,
  output logic              stall
);

  logic              done_q, done_d;
  logic              discard_q, discard_d;
  logic [DATA_W-1:0] buf_q, buf_d;
  logic              hit;
  logic              kill;
  logic              accept;

  always_comb begin
    kill   = HAS_DISCARD & flush;
    hit    = in_wait & data_ok & ~discard_q;
    accept = hit & ~kill;

    // clear before set: a completion on a retire edge is kept
    done_d = done_q;
    if (advance | kill) done_d = 1'b0;
    if (accept)         done_d = 1'b1;

    discard_d = discard_q;
    if (kill & (issued | in_wait)) discard_d = 1'b1;
    if (in_wait & data_ok)         discard_d = 1'b0;

    buf_d = buf_q;
    if (accept & load) buf_d = rdata;

    result = hit ? rdata : buf_q;
    stall  = en & ~done_q & ~hit;
    done   = done_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      done_q    <= 1'b0;
      discard_q <= 1'b0;
      buf_q     <= '0;
    end else begin
      done_q    <= done_d;
      discard_q <= discard_d;
      buf_q     <= buf_d;
    end
  end

endmodule

// File: rtl/mips_mem_bridge.sv
// Arbitrates MIPS fetch and memory channels onto
// one handshaked SRAM-like bus; raises stalls.
module mips_mem_bridge
  import mips_mem_bridge_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter bit D_FIRST = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              inst_en,
  input  logic [ADDR_W-1:0] pcF,
  output logic [DATA_W-1:0] instrF,
  input  logic              mem_en,
  input  logic              mem_wr,
  input  logic [1:0]        mem_size,
  input  logic [ADDR_W-1:0] aluoutM,
  input  logic [DATA_W-1:0] writedataM,
  output logic [DATA_W-1:0] readdataM,
  input  logic              advance,
  input  logic              flushF,
  output logic              stall_if,
  output logic              stall_mem,
  mips_mem_bridge_if.master bus
);

  state_e            state_q, state_d;
  logic              req_q, req_d;
  bus_ctl_t          ctl_q, ctl_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              i_done, d_done;
  logic              i_elig, d_elig;
  logic              i_issued;
  logic              i_wait, d_wait;

  assign i_elig   = inst_en & ~i_done;
  assign d_elig   = mem_en & ~d_done;
  assign i_wait   = (state_q == I_WAIT);
  assign d_wait   = (state_q == D_WAIT);
  assign i_issued = (state_q == I_ADDR) & bus.addr_ok;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (d_elig && (D_FIRST || !i_elig))
          state_d = D_ADDR;
        else if (i_elig)
          state_d = I_ADDR;
      end
      I_ADDR: if (bus.addr_ok) state_d = I_WAIT;
      I_WAIT: if (bus.data_ok) state_d = IDLE;
      D_ADDR: if (bus.addr_ok) state_d = D_WAIT;
      D_WAIT: if (bus.data_ok) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // bus fields are latched on IDLE exit and held
  // until the next issue
  always_comb begin
    req_d   = req_q;
    ctl_d   = ctl_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    unique case (1'b1)
      (state_q == IDLE) && (state_d == I_ADDR): begin
        req_d      = 1'b1;
        ctl_d.wr   = 1'b0;
        ctl_d.size = SZ_WORD;
        addr_d     = pcF;
        wdata_d    = '0;
      end
      (state_q == IDLE) && (state_d == D_ADDR): begin
        req_d      = 1'b1;
        ctl_d.wr   = mem_wr;
        ctl_d.size = mem_size;
        addr_d     = aluoutM;
        wdata_d    = writedataM;
      end
      (state_q == I_ADDR) && bus.addr_ok,
      (state_q == D_ADDR) && bus.addr_ok: begin
        req_d = 1'b0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      req_q   <= 1'b0;
      ctl_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      req_q   <= req_d;
      ctl_q   <= ctl_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  assign bus.req   = req_q;
  assign bus.wr    = ctl_q.wr;
  assign bus.size  = ctl_q.size;
  assign bus.addr  = addr_q;
  assign bus.wdata = wdata_q;

  mips_mem_chan #(
    .DATA_W      (DATA_W),
    .HAS_DISCARD (1'b1)
  ) u_f_chan (
    .clk     (clk),
    .rst     (rst),
    .en      (inst_en),
    .advance (advance),
    .flush   (flushF),
    .issued  (i_issued),
    .in_wait (i_wait),
    .data_ok (bus.data_ok),
    .load    (1'b1),
    .rdata   (bus.rdata),
    .result  (instrF),
    .done    (i_done),
    .stall   (stall_if)
  );

  mips_mem_chan #(
    .DATA_W      (DATA_W),
    .HAS_DISCARD (1'b0)
  ) u_m_chan (
    .clk     (clk),
    .rst     (rst),
    .en      (mem_en),
    .advance (advance),
    .flush   (1'b0),
    .issued  (1'b0),
    .in_wait (d_wait),
    .data_ok (bus.data_ok),
    .load    (~ctl_q.wr),
    .rdata   (bus.rdata),
    .result  (readdataM),
    .done    (d_done),
    .stall   (stall_mem)
  );

endmodule

// File: tb/tb_mips_mem_bridge.sv
// Directed bench for mips_mem_bridge: fetch, arbitration,
// delayed store, hold, flush and mid-op reset.
module tb_mips_mem_bridge;
  import mips_mem_bridge_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        inst_en, mem_en, mem_wr;
  logic        advance, flushF;
  logic [1:0]  mem_size;
  logic [31:0] pcF, aluoutM, writedataM;
  logic [31:0] instrF, readdataM;
  logic        stall_if, stall_mem;
  int          n_cmp = 0;
  int          n_bad = 0;

  mips_mem_bridge_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  mips_mem_bridge #(.ADDR_W(32), .DATA_W(32), .D_FIRST(1'b1)) dut (
    .clk        (clk),
    .rst        (rst),
    .inst_en    (inst_en),
    .pcF        (pcF),
    .instrF     (instrF),
    .mem_en     (mem_en),
    .mem_wr     (mem_wr),
    .mem_size   (mem_size),
    .aluoutM    (aluoutM),
    .writedataM (writedataM),
    .readdataM  (readdataM),
    .advance    (advance),
    .flushF     (flushF),
    .stall_if   (stall_if),
    .stall_mem  (stall_mem),
    .bus        (bus.master)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0; inst_en = 1'b0; mem_en = 1'b0; mem_wr = 1'b0;
    advance = 1'b0; flushF = 1'b0; mem_size = 2'd0;
    pcF = '0; aluoutM = '0; writedataM = '0;
    bus.addr_ok = 1'b0; bus.data_ok = 1'b0; bus.rdata = '0;
    @(negedge clk);
    n_cmp++; if (bus.req !== 1'b0) begin n_bad++; $display("FAIL rst_req got %b want 0", bus.req); end
    n_cmp++; if (bus.addr !== 32'h0) begin n_bad++; $display("FAIL rst_addr got %h want 0", bus.addr); end
    n_cmp++; if (bus.size !== 2'd0 || bus.wr !== 1'b0) begin n_bad++; $display("FAIL rst_ctl got %b/%b want 0/0", bus.size, bus.wr); end
    n_cmp++; if (instrF !== 32'h0 || readdataM !== 32'h0) begin n_bad++; $display("FAIL rst_data got %h/%h want 0/0", instrF, readdataM); end
    n_cmp++; if (stall_if !== 1'b0 || stall_mem !== 1'b0) begin n_bad++; $display("FAIL rst_stall got %b/%b want 0/0", stall_if, stall_mem); end
    cyc();
    rst = 1'b1;
    cyc();
  endtask

  task automatic test_fetch();
    inst_en = 1'b1; pcF = 32'hBFC00000;
    @(negedge clk);
    n_cmp++; if (stall_if !== 1'b1) begin n_bad++; $display("FAIL f_stall0 got %b want 1", stall_if); end
    n_cmp++; if (bus.req !== 1'b0) begin n_bad++; $display("FAIL f_req0 got %b want 0", bus.req); end
    cyc();
    bus.addr_ok = 1'b1;
    @(negedge clk);
    n_cmp++; if (bus.req !== 1'b1) begin n_bad++; $display("FAIL f_req1 got %b want 1", bus.req); end
    n_cmp++; if (bus.addr !== 32'hBFC00000) begin n_bad++; $display("FAIL f_addr got %h want bfc00000", bus.addr); end
    n_cmp++; if (bus.size !== SZ_WORD || bus.wr !== 1'b0) begin n_bad++; $display("FAIL f_ctl got %d/%b want 2/0", bus.size, bus.wr); end
    n_cmp++; if (stall_if !== 1'b1) begin n_bad++; $display("FAIL f_stall1 got %b want 1", stall_if); end
    cyc();
    bus.addr_ok = 1'b0; bus.data_ok = 1'b1; bus.rdata = 32'h24080001;
    @(negedge clk);
    n_cmp++; if (instrF !== 32'h24080001) begin n_bad++; $display("FAIL f_fwd got %h want 24080001", instrF); end
    n_cmp++; if (stall_if !== 1'b0) begin n_bad++; $display("FAIL f_stall2 got %b want 0", stall_if); end
    n_cmp++; if (bus.req !== 1'b0) begin n_bad++; $display("FAIL f_req2 got %b want 0", bus.req); end
    cyc();
    bus.data_ok = 1'b0; bus.rdata = '0;
    @(negedge clk);
    n_cmp++; if (instrF !== 32'h24080001) begin n_bad++; $display("FAIL f_buf got %h want 24080001", instrF); end
    n_cmp++; if (stall_if !== 1'b0) begin n_bad++; $display("FAIL f_stall3 got %b want 0", stall_if); end
  endtask

  task automatic test_hold();
    for (int k = 0; k < 5; k++) begin
      cyc();
      @(negedge clk);
      n_cmp++; if (instrF !== 32'h24080001) begin n_bad++; $display("FAIL hold_instr[%0d] got %h want 24080001", k, instrF); end
      n_cmp++; if (bus.req !== 1'b0) begin n_bad++; $display("FAIL hold_req[%0d] got %b want 0", k, bus.req); end
      n_cmp++; if (stall_if !== 1'b0) begin n_bad++; $display("FAIL hold_stall[%0d] got %b want 0", k, stall_if); end
    end
    advance = 1'b1;
    cyc();
    advance = 1'b0;
    @(negedge clk);
    n_cmp++; if (stall_if !== 1'b1) begin n_bad++; $display("FAIL retire_stall got %b want 1", stall_if); end
    n_cmp++; if (instrF !== 32'h24080001) begin n_bad++; $display("FAIL retire_buf got %h want 24080001", instrF); end
    inst_en = 1'b0;
    cyc();
    @(negedge clk);
    n_cmp++; if (bus.req !== 1'b0) begin n_bad++; $display("FAIL retire_req got %b want 0", bus.req); end
  endtask

  task automatic test_arbitrate();
    inst_en = 1'b1; pcF = 32'hBFC00004;
    mem_en = 1'b1; mem_wr = 1'b0; mem_size = SZ_WORD; aluoutM = 32'h80001000;
    @(negedge clk);
    n_cmp++; if (stall_if !== 1'b1 || stall_mem !== 1'b1) begin n_bad++; $display("FAIL arb_stall0 got %b/%b want 1/1", stall_if, stall_mem); end
    cyc();
    bus.addr_ok = 1'b1;
    @(negedge clk);
    n_cmp++; if (bus.req !== 1'b1 || bus.addr !== 32'h80001000) begin n_bad++; $display("FAIL arb_m_first got %b/%h want 1/80001000", bus.req, bus.addr); end
    n_cmp++; if (bus.wr !== 1'b0 || bus.size !== SZ_WORD) begin n_bad++; $display("FAIL arb_m_ctl got %b/%d want 0/2", bus.wr, bus.size); end
    cyc();
    bus.addr_ok = 1'b0; bus.data_ok = 1'b1; bus.rdata = 32'h11223344;
    @(negedge clk);
    n_cmp++; if (readdataM !== 32'h11223344) begin n_bad++; $display("FAIL arb_m_fwd got %h want 11223344", readdataM); end
    n_cmp++; if (stall_mem !== 1'b0 || stall_if !== 1'b1) begin n_bad++; $display("FAIL arb_stall2 got %b/%b want 0/1", stall_mem, stall_if); end
    cyc();
    bus.data_ok = 1'b0; bus.rdata = '0;
    @(negedge clk);
    n_cmp++; if (bus.req !== 1'b0 || stall_if !== 1'b1) begin n_bad++; $display("FAIL arb_gap got %b/%b want 0/1", bus.req, stall_if); end
    n_cmp++; if (readdataM !== 32'h11223344) begin n_bad++; $display("FAIL arb_m_buf got %h want 11223344", readdataM); end
    cyc();
    bus.addr_ok = 1'b1;
    @(negedge clk);
    n_cmp++; if (bus.req !== 1'b1 || bus.addr !== 32'hBFC00004) begin n_bad++; $display("FAIL arb_f_second got %b/%h want 1/bfc00004", bus.req, bus.addr); end
    cyc();
    bus.addr_ok = 1'b0; bus.data_ok = 1'b1; bus.rdata = 32'h8C090000;
    @(negedge clk);
    n_cmp++; if (instrF !== 32'h8C090000 || stall_if !== 1'b0) begin n_bad++; $display("FAIL arb_f_done got %h/%b want 8c090000/0", instrF, stall_if); end
    cyc();
    bus.data_ok = 1'b0; bus.rdata = '0;
    inst_en = 1'b0; mem_en = 1'b0; advance = 1'b1;
    cyc();
    advance = 1'b0;
  endtask

  task automatic test_store_delay();
    mem_en = 1'b1; mem_wr = 1'b1; mem_size = SZ_BYTE;
    aluoutM = 32'h80000003; writedataM = 32'hAB000000;
    @(negedge clk);
    n_cmp++; if (stall_mem !== 1'b1) begin n_bad++; $display("FAIL st_stall0 got %b want 1", stall_mem); end
    for (int k = 0; k < 4; k++) begin
      cyc();
      if (k == 3) bus.addr_ok = 1'b1;
      @(negedge clk);
      n_cmp++; if (bus.req !== 1'b1 || bus.addr !== 32'h80000003) begin n_bad++; $display("FAIL st_req[%0d] got %b/%h want 1/80000003", k, bus.req, bus.addr); end
      n_cmp++; if (bus.size !== SZ_BYTE || bus.wr !== 1'b1) begin n_bad++; $display("FAIL st_ctl[%0d] got %d/%b want 0/1", k, bus.size, bus.wr); end
      n_cmp++; if (bus.wdata !== 32'hAB000000) begin n_bad++; $display("FAIL st_wdata[%0d] got %h want ab000000", k, bus.wdata); end
      n_cmp++; if (stall_mem !== 1'b1) begin n_bad++; $display("FAIL st_stall[%0d] got %b want 1", k, stall_mem); end
    end
    cyc();
    bus.addr_ok = 1'b0;
    @(negedge clk);
    n_cmp++; if (bus.req !== 1'b0 || stall_mem !== 1'b1) begin n_bad++; $display("FAIL st_wait got %b/%b want 0/1", bus.req, stall_mem); end
    cyc();
    bus.data_ok = 1'b1; bus.rdata = 32'hFFFFFFFF;
    @(negedge clk);
    n_cmp++; if (stall_mem !== 1'b0) begin n_bad++; $display("FAIL st_done got %b want 0", stall_mem); end
    cyc();
    bus.data_ok = 1'b0; bus.rdata = '0;
    @(negedge clk);
    n_cmp++; if (readdataM !== 32'h11223344) begin n_bad++; $display("FAIL st_nobuf got %h want 11223344", readdataM); end
    n_cmp++; if (stall_mem !== 1'b0 || bus.req !== 1'b0) begin n_bad++; $display("FAIL st_held got %b/%b want 0/0", stall_mem, bus.req); end
    mem_en = 1'b0; mem_wr = 1'b0; advance = 1'b1;
    cyc();
    advance = 1'b0;
  endtask

  task automatic test_flush();
    inst_en = 1'b1; pcF = 32'hBFC00008;
    cyc();
    bus.addr_ok = 1'b1;
    cyc();
    bus.addr_ok = 1'b0; flushF = 1'b1; pcF = 32'hBFC00100;
    @(negedge clk);
    n_cmp++; if (stall_if !== 1'b1) begin n_bad++; $display("FAIL fl_stall0 got %b want 1", stall_if); end
    cyc();
    flushF = 1'b0; bus.data_ok = 1'b1; bus.rdata = 32'hDEADBEEF;
    @(negedge clk);
    n_cmp++; if (instrF !== 32'h8C090000) begin n_bad++; $display("FAIL fl_drop got %h want 8c090000", instrF); end
    n_cmp++; if (stall_if !== 1'b1) begin n_bad++; $display("FAIL fl_stall1 got %b want 1", stall_if); end
    cyc();
    bus.data_ok = 1'b0; bus.rdata = '0;
    @(negedge clk);
    n_cmp++; if (bus.req !== 1'b0 || stall_if !== 1'b1) begin n_bad++; $display("FAIL fl_idle got %b/%b want 0/1", bus.req, stall_if); end
    n_cmp++; if (instrF === 32'hDEADBEEF) begin n_bad++; $display("FAIL fl_leak got %h want not deadbeef", instrF); end
    cyc();
    bus.addr_ok = 1'b1;
    @(negedge clk);
    n_cmp++; if (bus.req !== 1'b1 || bus.addr !== 32'hBFC00100) begin n_bad++; $display("FAIL fl_reissue got %b/%h want 1/bfc00100", bus.req, bus.addr); end
    cyc();
    bus.addr_ok = 1'b0; bus.data_ok = 1'b1; bus.rdata = 32'h3C1D8000;
    @(negedge clk);
    n_cmp++; if (instrF !== 32'h3C1D8000 || stall_if !== 1'b0) begin n_bad++; $display("FAIL fl_done got %h/%b want 3c1d8000/0", instrF, stall_if); end
    cyc();
    bus.data_ok = 1'b0; bus.rdata = '0;
    @(negedge clk);
    n_cmp++; if (instrF !== 32'h3C1D8000) begin n_bad++; $display("FAIL fl_buf got %h want 3c1d8000", instrF); end
    inst_en = 1'b0; advance = 1'b1;
    cyc();
    advance = 1'b0;
  endtask

  task automatic test_reset_mid();
    inst_en = 1'b1; pcF = 32'hBFC00200;
    mem_en = 1'b1; mem_wr = 1'b0; mem_size = SZ_WORD; aluoutM = 32'h80002000;
    cyc();
    bus.addr_ok = 1'b1;
    cyc();
    bus.addr_ok = 1'b0;
    @(negedge clk);
    n_cmp++; if (dut.state_q !== D_WAIT) begin n_bad++; $display("FAIL rm_pre got %0d want %0d", dut.state_q, D_WAIT); end
    #1 rst = 1'b0;
    #1;
    n_cmp++; if (dut.state_q !== IDLE) begin n_bad++; $display("FAIL rm_state got %0d want %0d", dut.state_q, IDLE); end
    n_cmp++; if (bus.req !== 1'b0 || bus.addr !== 32'h0) begin n_bad++; $display("FAIL rm_bus got %b/%h want 0/0", bus.req, bus.addr); end
    n_cmp++; if (stall_mem !== 1'b1 || stall_if !== 1'b1) begin n_bad++; $display("FAIL rm_stall got %b/%b want 1/1", stall_mem, stall_if); end
    n_cmp++; if (readdataM !== 32'h0 || instrF !== 32'h0) begin n_bad++; $display("FAIL rm_data got %h/%h want 0/0", readdataM, instrF); end
    inst_en = 1'b0; mem_en = 1'b0;
    cyc();
    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      cyc();
      @(negedge clk);
      n_cmp++; if (bus.req !== 1'b0) begin n_bad++; $display("FAIL rm_quiet[%0d] got %b want 0", k, bus.req); end
    end
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_hold();
    test_arbitrate();
    test_store_delay();
    test_flush();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
